word_assembler: RTL and testbench

- Narrow-in, wide-out gearbox: collects SYM_WIDTH-bit symbols and emits full WORD_WIDTH-bit words.
- Inverse of the transmit-side parallel-in buffer that barrel-shifts words out LSB symbol first.
- Sits on the receive path after the BPSK symbol/bit decision stage and rebuilds data words for downstream logic.
- Valid/ready on both sides, with a one-word output holding register so assembly continues while a finished word waits.

---
 rtl/word_assembler.sv | 116 +++++++++++
 tb/tb_word_assembler.sv | 247 ++++++++++++++++++++++++
 2 files changed

// File: rtl/word_assembler.sv
// word_assembler: narrow-to-wide symbol gearbox with a one-word output register.
// Define WORD_ASSEMBLER_MSB_FIRST_EN to place the first symbol in the MSB slot.
module word_assembler #(
  parameter  int WORD_WIDTH = 16,
  parameter  int SYM_WIDTH  = 4,
  localparam int N          = WORD_WIDTH / SYM_WIDTH,
  localparam int CNT_W      = $clog2(N)
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic [SYM_WIDTH-1:0]  sym_in,
  input  logic                  sym_valid,
  output logic                  sym_ready,
  input  logic                  sync,
  output logic [WORD_WIDTH-1:0] word_out,
  output logic                  word_valid,
  input  logic                  word_ready,
  output logic [CNT_W-1:0]      fill_level
);

  localparam logic [CNT_W-1:0] LAST = CNT_W'(N - 1);

  if ((WORD_WIDTH % SYM_WIDTH) != 0 || N < 2) begin : g_bad_cfg
    $error("word_assembler: WORD_WIDTH must be >= 2 whole SYM_WIDTH symbols");
  end

  logic [WORD_WIDTH-1:0] acc_q, acc_d;
  logic [WORD_WIDTH-1:0] word_q, word_d;
  logic [CNT_W-1:0]      cnt_q, cnt_d;
  logic                  valid_q, valid_d;

  logic                  at_last;
  logic                  accept;
  logic                  do_sync;
  logic                  do_fill;
  logic                  do_done;

  logic [WORD_WIDTH-1:0] acc_ins;
  logic [WORD_WIDTH-1:0] word_full;
  logic [WORD_WIDTH-1:0] acc_first;

  assign at_last    = (cnt_q == LAST);
  assign sym_ready  = !valid_q || word_ready || !at_last;
  assign accept     = sym_valid && sym_ready;
  assign do_sync    = sync;
  assign do_done    = accept && !sync && at_last;
  assign do_fill    = accept && !sync && !at_last;

  assign word_out   = word_q;
  assign word_valid = valid_q;
  assign fill_level = cnt_q;

  always_comb begin
    acc_first = WORD_WIDTH'(sym_in);
`ifdef WORD_ASSEMBLER_MSB_FIRST_EN
    // Shift in from the LSB end so the first symbol ends up on top.
    acc_ins   = {acc_q[WORD_WIDTH-SYM_WIDTH-1:0], sym_in};
    word_full = acc_ins;
`else
    acc_ins = acc_q;
    for (int i = 0; i < N; i++) begin
      if (cnt_q == CNT_W'(i)) begin
        acc_ins[i*SYM_WIDTH +: SYM_WIDTH] = sym_in;
      end
    end
    word_full = acc_q;
    word_full[WORD_WIDTH-1 -: SYM_WIDTH] = sym_in;
`endif
  end

  always_comb begin
    acc_d   = acc_q;
    cnt_d   = cnt_q;
    word_d  = word_q;
    valid_d = valid_q;
    if (valid_q && word_ready) begin
      valid_d = 1'b0;
    end
    unique case (1'b1)
      do_sync: begin
        acc_d = '0;
        cnt_d = '0;
        if (accept) begin
          acc_d = acc_first;
          cnt_d = CNT_W'(1);
        end
      end
      do_done: begin
        word_d  = word_full;
        valid_d = 1'b1;
        acc_d   = '0;
        cnt_d   = '0;
      end
      do_fill: begin
        acc_d = acc_ins;
        cnt_d = cnt_q + CNT_W'(1);
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      acc_q   <= '0;
      cnt_q   <= '0;
      word_q  <= '0;
      valid_q <= 1'b0;
    end else begin
      acc_q   <= acc_d;
      cnt_q   <= cnt_d;
      word_q  <= word_d;
      valid_q <= valid_d;
    end
  end

endmodule

// File: tb/tb_word_assembler.sv
// tb_word_assembler: scripted scenarios with an expected-word queue.
// Build with WORD_ASSEMBLER_MSB_FIRST_EN to check the MSB-first ordering.
module tb_word_assembler;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [3:0]  sym_in;
  logic        sym_valid;
  logic        sym_ready;
  logic        sync;
  logic [15:0] word_out;
  logic        word_valid;
  logic        word_ready;
  logic [1:0]  fill_level;

  int checks = 0;
  int errors = 0;
  logic [15:0] sb[$];
  logic [15:0] exp_w;

  always #5 clk = ~clk;

  word_assembler #(.WORD_WIDTH(16), .SYM_WIDTH(4)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .sym_in    (sym_in),
    .sym_valid (sym_valid),
    .sym_ready (sym_ready),
    .sync      (sync),
    .word_out  (word_out),
    .word_valid(word_valid),
    .word_ready(word_ready),
    .fill_level(fill_level)
  );

  function automatic logic [15:0] pack(input logic [3:0] s0, input logic [3:0] s1,
                                       input logic [3:0] s2, input logic [3:0] s3);
`ifdef WORD_ASSEMBLER_MSB_FIRST_EN
    return {s0, s1, s2, s3};
`else
    return {s3, s2, s1, s0};
`endif
  endfunction

  task automatic cyc();
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic drive(input logic [3:0] s, input logic v, input logic sy, input logic wr);
    sym_in     = s;
    sym_valid  = v;
    sync       = sy;
    word_ready = wr;
    #1;
  endtask

  task automatic test_reset();
    if (word_valid !== 1'b0) begin errors++; $display("FAIL reset_valid: got %b want 0", word_valid); end
    checks++;
    if (word_out !== 16'h0) begin errors++; $display("FAIL reset_word: got %h want 0000", word_out); end
    checks++;
    if (fill_level !== 2'd0) begin errors++; $display("FAIL reset_fill: got %0d want 0", fill_level); end
    checks++;
    if (sym_ready !== 1'b1) begin errors++; $display("FAIL reset_ready: got %b want 1", sym_ready); end
    checks++;
  endtask

  task automatic test_basic();
    logic [3:0] s;
    for (int i = 0; i < 4; i++) begin
      s = 4'(i + 1);
      drive(s, 1'b1, 1'b0, 1'b1);
      if (fill_level !== 2'(i)) begin errors++; $display("FAIL basic_fill%0d: got %0d want %0d", i, fill_level, i); end
      checks++;
      if (word_valid !== 1'b0) begin errors++; $display("FAIL basic_early%0d: got %b want 0", i, word_valid); end
      checks++;
      if (i == 3) sb.push_back(pack(4'h1, 4'h2, 4'h3, 4'h4));
      cyc();
    end
    drive(4'h0, 1'b0, 1'b0, 1'b1);
    exp_w = sb.pop_front();
    if (word_valid !== 1'b1) begin errors++; $display("FAIL basic_valid: got %b want 1", word_valid); end
    checks++;
    if (word_out !== exp_w) begin errors++; $display("FAIL basic_word: got %h want %h", word_out, exp_w); end
    checks++;
    if (fill_level !== 2'd0) begin errors++; $display("FAIL basic_fill4: got %0d want 0", fill_level); end
    checks++;
    cyc();
    if (word_valid !== 1'b0) begin errors++; $display("FAIL basic_drop: got %b want 0", word_valid); end
    checks++;
  endtask

  task automatic test_stream();
    for (int i = 0; i <= 12; i++) begin
      if (i < 12) drive(4'(i), 1'b1, 1'b0, 1'b1);
      else        drive(4'h0, 1'b0, 1'b0, 1'b1);
      if (i > 0 && i % 4 == 0) begin
        exp_w = sb.pop_front();
        if (word_valid !== 1'b1 || word_out !== exp_w) begin
          errors++;
          $display("FAIL stream_word%0d: got v=%b %h want v=1 %h", i, word_valid, word_out, exp_w);
        end
      end else if (word_valid !== 1'b0) begin
        errors++;
        $display("FAIL stream_gap%0d: got v=%b want 0", i, word_valid);
      end
      checks++;
      if (i < 12) begin
        if (sym_ready !== 1'b1) begin errors++; $display("FAIL stream_ready%0d: got %b want 1", i, sym_ready); end
        checks++;
        if (i % 4 == 3) sb.push_back(pack(4'(i - 3), 4'(i - 2), 4'(i - 1), 4'(i)));
      end
      cyc();
    end
  endtask

  task automatic test_backpressure();
    logic [15:0] held;
    held = 16'h0;
    for (int i = 0; i < 7; i++) begin
      drive(4'(i + 1), 1'b1, 1'b0, 1'b0);
      if (sym_ready !== 1'b1) begin errors++; $display("FAIL bp_ready%0d: got %b want 1", i, sym_ready); end
      checks++;
      if (i == 3) sb.push_back(pack(4'h1, 4'h2, 4'h3, 4'h4));
      if (i == 4) begin
        held = sb.pop_front();
      end
      if (i >= 4) begin
        if (word_valid !== 1'b1 || word_out !== held) begin
          errors++;
          $display("FAIL bp_hold%0d: got v=%b %h want v=1 %h", i, word_valid, word_out, held);
        end
        checks++;
      end
      cyc();
    end
    for (int k = 0; k < 2; k++) begin
      drive(4'h8, 1'b1, 1'b0, 1'b0);
      if (sym_ready !== 1'b0) begin errors++; $display("FAIL bp_stall%0d: got %b want 0", k, sym_ready); end
      checks++;
      if (word_valid !== 1'b1 || word_out !== held || fill_level !== 2'd3) begin
        errors++;
        $display("FAIL bp_stable%0d: got v=%b %h f=%0d want v=1 %h f=3", k, word_valid, word_out, fill_level, held);
      end
      checks++;
      cyc();
    end
    drive(4'h8, 1'b1, 1'b0, 1'b1);
    if (sym_ready !== 1'b1) begin errors++; $display("FAIL bp_release: got %b want 1", sym_ready); end
    checks++;
    sb.push_back(pack(4'h5, 4'h6, 4'h7, 4'h8));
    cyc();
    drive(4'h0, 1'b0, 1'b0, 1'b1);
    exp_w = sb.pop_front();
    if (word_valid !== 1'b1 || word_out !== exp_w) begin
      errors++;
      $display("FAIL bp_second: got v=%b %h want v=1 %h", word_valid, word_out, exp_w);
    end
    checks++;
    cyc();
    if (word_valid !== 1'b0) begin errors++; $display("FAIL bp_drain: got %b want 0", word_valid); end
    checks++;
  endtask

  task automatic test_sync();
    drive(4'hA, 1'b1, 1'b0, 1'b1); cyc();
    drive(4'hB, 1'b1, 1'b0, 1'b1); cyc();
    if (fill_level !== 2'd2) begin errors++; $display("FAIL sync_pre: got %0d want 2", fill_level); end
    checks++;
    drive(4'h1, 1'b1, 1'b1, 1'b1); cyc();
    if (fill_level !== 2'd1) begin errors++; $display("FAIL sync_fill: got %0d want 1", fill_level); end
    checks++;
    drive(4'h2, 1'b1, 1'b0, 1'b1); cyc();
    drive(4'h3, 1'b1, 1'b0, 1'b1); cyc();
    if (word_valid !== 1'b0) begin errors++; $display("FAIL sync_early: got %b want 0", word_valid); end
    checks++;
    drive(4'h4, 1'b1, 1'b0, 1'b1);
    sb.push_back(pack(4'h1, 4'h2, 4'h3, 4'h4));
    cyc();
    drive(4'h0, 1'b0, 1'b0, 1'b1);
    exp_w = sb.pop_front();
    if (word_valid !== 1'b1 || word_out !== exp_w) begin
      errors++;
      $display("FAIL sync_word: got v=%b %h want v=1 %h", word_valid, word_out, exp_w);
    end
    checks++;
    cyc();
  endtask

  task automatic test_reset_mid();
    for (int i = 0; i < 6; i++) begin
      drive(4'(i + 1), 1'b1, 1'b0, 1'b0);
      cyc();
    end
    drive(4'h0, 1'b0, 1'b0, 1'b0);
    if (word_valid !== 1'b1 || fill_level !== 2'd2) begin
      errors++;
      $display("FAIL rst_setup: got v=%b f=%0d want v=1 f=2", word_valid, fill_level);
    end
    checks++;
    #1 rst_n = 1'b0;
    #1;
    if (word_valid !== 1'b0 || word_out !== 16'h0 || fill_level !== 2'd0) begin
      errors++;
      $display("FAIL rst_async: got v=%b %h f=%0d want v=0 0000 f=0", word_valid, word_out, fill_level);
    end
    checks++;
    sb.delete();
    @(negedge clk);
    rst_n = 1'b1;
    for (int i = 0; i < 4; i++) begin
      drive(4'(i + 9), 1'b1, 1'b0, 1'b1);
      if (i == 3) sb.push_back(pack(4'h9, 4'hA, 4'hB, 4'hC));
      cyc();
    end
    drive(4'h0, 1'b0, 1'b0, 1'b1);
    exp_w = sb.pop_front();
    if (word_valid !== 1'b1 || word_out !== exp_w) begin
      errors++;
      $display("FAIL rst_fresh: got v=%b %h want v=1 %h", word_valid, word_out, exp_w);
    end
    checks++;
    cyc();
  endtask

  initial begin
    rst_n      = 1'b0;
    sym_in     = 4'h0;
    sym_valid  = 1'b0;
    sync       = 1'b0;
    word_ready = 1'b1;
    #1;
    test_reset();
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    test_basic();
    test_stream();
    test_backpressure();
    test_sync();
    test_reset_mid();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
